sccb_config_sequencer: RTL and testbench

// - Sequences camera bring-up: power-up wait, walks a register table {reg,val}, writes each entry as 3-byte SCCB phase (ID, reg, val).
// - Drives the byte-level I2C engine through a strobe/busy handshake.
// - After the table completes, releases frame capture (capture_en) aligned to the first vsync falling edge.
// - Sits between the register-table ROM, the I2C byte engine and the frame grabber.

---
 rtl/sccb_config_sequencer_pkg.sv | 37 +++
 rtl/sccb_byte_issuer.sv | 53 +++++
 rtl/sccb_config_sequencer.sv | 139 +++++++++++++
 tb/tb_sccb_config_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sccb_config_sequencer_pkg.sv
// sccb_cfg_pkg: shared states, SCCB constants and helpers for the config sequencer (SCCB_SOFT_RESET_EN adds soft-reset states)
package sccb_cfg_pkg;
  localparam logic [7:0] SCCB_END_MARKER = 8'hFF;
  localparam logic [7:0] COM7_ADDR       = 8'h12;
  localparam logic [7:0] COM7_RESET      = 8'h80;
  localparam int         ACCEPT_TIMEOUT  = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
`ifdef SCCB_SOFT_RESET_EN
    S_SRST_ID,
    S_SRST_REG,
    S_SRST_VAL,
    S_SRST_WAIT,
`endif
    S_FETCH,
    S_ID,
    S_REG,
    S_VAL,
    S_GAP,
    S_SYNC,
    S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_ACC,
    I_BUSY
  } iss_phase_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sccb_byte_issuer.sv
// sccb_byte_issuer: one-byte strobe/accept/done handshake with the I2C byte engine, re-strobing on accept timeout
module sccb_byte_issuer
  import sccb_cfg_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic byte_busy,
  output logic strobe,
  output logic done
);
  iss_phase_t phase_q, phase_d;
  logic [2:0] cnt_q, cnt_d;

  // Strobe only into an idle engine; count cycles since strobe while waiting for accept
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    done    = 1'b0;
    case (phase_q)
      I_IDLE: if (req && !byte_busy) begin
        strobe  = 1'b1;
        phase_d = I_ACC;
        cnt_d   = 3'd1;
      end
      I_ACC: if (byte_busy) begin
        phase_d = I_BUSY;
      end else if (cnt_q == 3'(ACCEPT_TIMEOUT)) begin
        strobe = 1'b1;
        cnt_d  = 3'd1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      I_BUSY: if (!byte_busy) begin
        done    = 1'b1;
        phase_d = I_IDLE;
      end
      default: phase_d = I_IDLE;
    endcase
  end

  // Handshake phase and accept-timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= I_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: camera bring-up (power-up wait, ROM table over SCCB, vsync-aligned capture enable); SCCB_SOFT_RESET_EN adds a COM7 soft reset first
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES    = 6_000_000,
  parameter int unsigned GAP_CYCLES      = 500,
  parameter int unsigned SOFT_RST_CYCLES = 50_000,
  parameter int unsigned ROM_AW          = 6,
  parameter logic [7:0]  DEV_ADDR        = 8'h42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              byte_strobe,
  output logic [7:0]        byte_data,
  output logic              byte_last,
  input  logic              byte_busy,
  input  logic              vsync,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              capture_en,
  output logic [ROM_AW:0]   write_count
);
  localparam int unsigned MAX_CYC = max3(PWRUP_CYCLES, GAP_CYCLES, SOFT_RST_CYCLES);
  localparam int          CW      = $clog2(MAX_CYC) + 1;

  seq_state_t        state_q, state_d;
  logic [CW-1:0]     dly_q, dly_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_AW:0]   write_count_q, write_count_d;
  logic              capture_en_q, capture_en_d;
  logic [2:0]        vs_q, vs_d;
  logic              vs_fall, req, done;

  assign vs_d        = {vs_q[1:0], vsync};
  assign vs_fall     = vs_q[2] & ~vs_q[1];
  assign rom_addr    = rom_addr_q;
  assign write_count = write_count_q;
  assign capture_en  = capture_en_q;
  assign cfg_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cfg_done    = (state_q == S_DONE);

  sccb_byte_issuer u_issuer (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .byte_busy (byte_busy),
    .strobe    (byte_strobe),
    .done      (done)
  );

  // Byte to send is a pure function of state; rom_addr is frozen from FETCH through VAL so it holds through WAIT
  always_comb begin
    byte_data = 8'h00;
    byte_last = 1'b0;
    req       = 1'b0;
    case (state_q)
      S_ID:  begin byte_data = DEV_ADDR;       req = 1'b1; end
      S_REG: begin byte_data = rom_data[15:8]; req = 1'b1; end
      S_VAL: begin byte_data = rom_data[7:0];  req = 1'b1; byte_last = 1'b1; end
`ifdef SCCB_SOFT_RESET_EN
      S_SRST_ID:  begin byte_data = DEV_ADDR;   req = 1'b1; end
      S_SRST_REG: begin byte_data = COM7_ADDR;  req = 1'b1; end
      S_SRST_VAL: begin byte_data = COM7_RESET; req = 1'b1; byte_last = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Sequencer next state; the delay counter free-runs down to 0 and is reloaded on entry to each timed state
  always_comb begin
    state_d       = state_q;
    dly_d         = (dly_q == '0) ? dly_q : dly_q - CW'(1);
    rom_addr_d    = rom_addr_q;
    write_count_d = write_count_q;
    capture_en_d  = capture_en_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_PWRUP;
        dly_d   = CW'(PWRUP_CYCLES - 1);
      end
`ifdef SCCB_SOFT_RESET_EN
      S_PWRUP:    if (dly_q == '0) state_d = S_SRST_ID;
      S_SRST_ID:  if (done) state_d = S_SRST_REG;
      S_SRST_REG: if (done) state_d = S_SRST_VAL;
      S_SRST_VAL: if (done) begin
        state_d = S_SRST_WAIT;
        dly_d   = CW'(SOFT_RST_CYCLES - 1);
      end
      S_SRST_WAIT: if (dly_q == '0) state_d = S_FETCH;
`else
      S_PWRUP: if (dly_q == '0) state_d = S_FETCH;
`endif
      S_FETCH: state_d = (rom_data[15:8] == SCCB_END_MARKER || write_count_q[ROM_AW]) ? S_SYNC : S_ID;
      S_ID:    if (done) state_d = S_REG;
      S_REG:   if (done) state_d = S_VAL;
      S_VAL: if (done) begin
        state_d       = S_GAP;
        dly_d         = CW'(GAP_CYCLES - 1);
        rom_addr_d    = rom_addr_q + ROM_AW'(1);
        write_count_d = write_count_q[ROM_AW] ? write_count_q : write_count_q + (ROM_AW+1)'(1);
      end
      S_GAP: if (dly_q == '0) state_d = S_FETCH;
      S_SYNC: if (vs_fall) begin
        state_d      = S_DONE;
        capture_en_d = 1'b1;
      end
      S_DONE: if (start) begin
        state_d       = S_PWRUP;
        dly_d         = CW'(PWRUP_CYCLES - 1);
        capture_en_d  = 1'b0;
        rom_addr_d    = '0;
        write_count_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, delay counter, table pointer, write count, capture enable and vsync synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      dly_q         <= '0;
      rom_addr_q    <= '0;
      write_count_q <= '0;
      capture_en_q  <= 1'b0;
      vs_q          <= '0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      rom_addr_q    <= rom_addr_d;
      write_count_q <= write_count_d;
      capture_en_q  <= capture_en_d;
      vs_q          <= vs_d;
    end
  end
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer: randomized tables against a byte-stream reference model with a 5-cycle-busy byte engine
module tb_sccb_config_sequencer;
  localparam int AW = 3;
  localparam int PW = 20;
  localparam int GP = 3;
  localparam int SR = 10;
`ifdef SCCB_SOFT_RESET_EN
  localparam int PRE = 3;
`else
  localparam int PRE = 0;
`endif

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, vsync = 1'b0;
  logic          byte_busy, byte_strobe, byte_last, cfg_busy, cfg_done, capture_en;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [7:0]    byte_data;
  logic [AW:0]   write_count;
  logic [15:0]   rom [8];
  logic [8:0]    got [$];
  logic [8:0]    exp_q [$];
  int            got_cyc [$];
  int            n_vec = 0, n_err = 0, cyc = 0, eng_cnt = 0, drop_cyc = 0, rel_cyc = 0;
  bit            stb_n = 0, drop_next = 0, dropped = 0;

  always #5 clk = ~clk;
  assign rom_data  = rom[rom_addr];
  assign byte_busy = (eng_cnt != 0);

  sccb_config_sequencer #(
    .PWRUP_CYCLES(PW), .GAP_CYCLES(GP), .SOFT_RST_CYCLES(SR), .ROM_AW(AW), .DEV_ADDR(8'h42)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .byte_strobe(byte_strobe), .byte_data(byte_data), .byte_last(byte_last), .byte_busy(byte_busy),
    .vsync(vsync), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .capture_en(capture_en),
    .write_count(write_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
    end
  endtask

  // Byte engine model: busy for 5 cycles after an accepted strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stb_n) eng_cnt <= 5;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end

  // Monitor: log strobes mid-cycle, optionally swallow one to force a re-strobe
  always @(negedge clk) begin
    stb_n = 1'b0;
    if (byte_strobe) begin
      check("stb_when_idle", byte_busy, 0);
      if (drop_next) begin
        drop_next = 1'b0;
        dropped   = 1'b1;
        drop_cyc  = cyc;
        check("dropped_byte", byte_data, 8'h42);
      end else begin
        stb_n = 1'b1;
        got.push_back({byte_last, byte_data});
        got_cyc.push_back(cyc);
        if (dropped) begin
          dropped = 1'b0;
          check("restrobe_delay", cyc - drop_cyc, 4);
          check("restrobe_byte", byte_data, 8'h42);
        end
      end
    end
  end

  function automatic void build_exp(output int n);
    exp_q.delete();
    n = 0;
`ifdef SCCB_SOFT_RESET_EN
    exp_q.push_back({1'b0, 8'h42});
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b1, 8'h80});
`endif
    for (int i = 0; i < 8; i++) begin
      if (rom[i][15:8] == 8'hFF) break;
      exp_q.push_back({1'b0, 8'h42});
      exp_q.push_back({1'b0, rom[i][15:8]});
      exp_q.push_back({1'b1, rom[i][7:0]});
      n++;
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic new_run();
    got.delete();
    got_cyc.delete();
    pulse_start();
    check("restart_capture_off", capture_en, 0);
    check("restart_busy", cfg_busy, 1);
    check("restart_not_done", cfg_done, 0);
  endtask

  task automatic finish_run(input string tag);
    int n, k, d, lo;
    build_exp(n);
    repeat (PW + 5) @(posedge clk);
    k = 0;
    while (got.size() < exp_q.size() && k < 4000) begin @(posedge clk); k++; end
    repeat (25) @(posedge clk);
    @(negedge clk);
    check({tag, "_sync_not_done"}, cfg_done, 0);
    check({tag, "_sync_capture_off"}, capture_en, 0);
    check({tag, "_sync_busy"}, cfg_busy, 1);
    #($urandom_range(1, 4)) vsync = 1'b1;
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #($urandom_range(1, 4)) vsync = 1'b0;
    k = 0;
    while (!cfg_done && k < 20) begin @(posedge clk); k++; end
    @(negedge clk);
    check({tag, "_done"}, cfg_done, 1);
    check({tag, "_capture_en"}, capture_en, 1);
    check({tag, "_idle_busy"}, cfg_busy, 0);
    check({tag, "_write_count"}, write_count, n);
    check({tag, "_rom_addr"}, rom_addr, n % 8);
    check({tag, "_byte_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_byte"}, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
    for (int i = 3; i < got.size(); i += 3) begin
      d  = got_cyc[i] - got_cyc[i-1];
      lo = 6 + ((PRE == 3 && i == 3) ? SR : GP);
      check({tag, "_write_gap"}, (d >= lo && d <= lo + 4), 1);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got %0d expected finish", n_vec);
    $fatal(1);
  end

  initial begin
    int k, n;
    rom[0] = 16'h1204;
    rom[1] = 16'h1101;
    rom[2] = 16'hFF00;
    for (int i = 3; i < 8; i++) rom[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("rst_strobe", byte_strobe, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_capture", capture_en, 0);
    check("rst_write_count", write_count, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_last", byte_last, 0);
    rel_cyc = cyc;
    reset   = 1'b1;
    finish_run("directed");
    check("pwrup_latency", (got_cyc.size() > 0) && (got_cyc[0] - rel_cyc >= PW) && (got_cyc[0] - rel_cyc <= PW + 4), 1);

    new_run();
    k = 0;
    while (got.size() < 3 && k < 2000) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    k = 0;
    while (byte_busy && k < 20) begin @(negedge clk); k++; end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("midrun_start_busy", cfg_busy, 1);
    finish_run("rerun");

    new_run();
    k = 0;
    while (got.size() < 5 + PRE && k < 2000) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_strobe", byte_strobe, 0);
    check("abort_busy", cfg_busy, 0);
    check("abort_done", cfg_done, 0);
    check("abort_capture", capture_en, 0);
    check("abort_write_count", write_count, 0);
    check("abort_rom_addr", rom_addr, 0);
    check("abort_byte_last", byte_last, 0);
    @(negedge clk);
    got.delete();
    got_cyc.delete();
    reset = 1'b1;
    finish_run("abort_rerun");

    drop_next = 1'b1;
    new_run();
    finish_run("restrobe");
    check("restrobe_happened", {drop_next, dropped}, 2'b00);

    for (int i = 0; i < 8; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    new_run();
    finish_run("full_table");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      rom[n] = {8'hFF, 8'($urandom)};
      new_run();
      finish_run("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
